dsp_mac_slice: RTL and testbench

Parametrised successor to the fixed-width DSP48A1 slice. It is a signed pre-adder, multiplier and post-adder MAC with a valid-tagged 4-stage pipeline, global clock enable, back-to-back accumulate, optional saturation with a sticky overflow flag, and pattern detect. It sits where the DSP48A1 sat in the datapath and cascades through `pcin`/`pcout`. All operand widths are set by parameters.

---
 rtl/dsp_mac_slice.sv | 126 ++++++++++++
 tb/tb_dsp_mac_slice.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dsp_mac_slice.sv
// Signed pre-adder / multiplier / post-adder MAC slice with a valid-tagged
// four-register pipeline, accumulate feedback, optional saturation and pattern detect.
module dsp_mac_slice #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int DW = 18,
  parameter int PW = 48,
  parameter bit SAT_EN = 1'b0,
  parameter logic [PW-1:0] PATTERN = '0,
  parameter logic [PW-1:0] MASK = '0,
  localparam int BCW = ((BW > DW) ? BW : DW) + 1,
  localparam int MW = AW + BCW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [5:0]           opmode,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [DW-1:0] d,
  input  logic signed [PW-1:0] c,
  input  logic signed [PW-1:0] pcin,
  input  logic                 ovf_clr,
  output logic signed [BCW-1:0] bcout,
  output logic signed [MW-1:0]  m,
  output logic signed [PW-1:0]  p,
  output logic signed [PW-1:0]  pcout,
  output logic                 out_valid,
  output logic                 carryout,
  output logic                 ovf,
  output logic                 pdet
);

  logic signed [AW-1:0] a1, a2;
  logic signed [BW-1:0] b1;
  logic signed [DW-1:0] d1;
  logic signed [PW-1:0] c1, c2, c3, pcin1, pcin2, pcin3;
  logic [5:0]           op1, op2, op3;
  logic                 v1, v2, v3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; pcin1 <= '0; op1 <= '0; v1 <= 1'b0;
    end else if (ce) begin
      a1 <= a; b1 <= b; d1 <= d; c1 <= c; pcin1 <= pcin; op1 <= opmode; v1 <= in_valid;
    end
  end

  logic signed [BCW-1:0] b_ext, d_ext, pre_sum;
  assign b_ext = BCW'(b1);
  assign d_ext = BCW'(d1);

  always_comb begin
    pre_sum = b_ext;
    if (op1[0]) pre_sum = op1[1] ? (d_ext - b_ext) : (d_ext + b_ext);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcout <= '0; a2 <= '0; c2 <= '0; pcin2 <= '0; op2 <= '0; v2 <= 1'b0;
    end else if (ce) begin
      bcout <= pre_sum; a2 <= a1; c2 <= c1; pcin2 <= pcin1; op2 <= op1; v2 <= v1;
    end
  end

  logic signed [MW-1:0] prod;
  assign prod = MW'(a2) * MW'(bcout);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m <= '0; c3 <= '0; pcin3 <= '0; op3 <= '0; v3 <= 1'b0;
    end else if (ce) begin
      m <= prod; c3 <= c2; pcin3 <= pcin2; op3 <= op2; v3 <= v2;
    end
  end

  // Z=2 feeds back the live p register so accumulate chains run without bubbles.
  logic signed [PW-1:0] z;
  always_comb begin
    case (op3[3:2])
      2'd0:    z = '0;
      2'd1:    z = c3;
      2'd2:    z = p;
      default: z = pcin3;
    endcase
  end

  logic [PW:0]   zx, mx, cin_w, sum, usum;
  logic [PW-1:0] p_next;
  logic          ovf_now, carry_next, pdet_next;

  assign zx    = (PW+1)'(z);
  assign mx    = (PW+1)'(m);
  assign cin_w = (PW+1)'(op3[5]);

  always_comb begin
    sum  = op3[4] ? (zx - mx - cin_w) : (zx + mx + cin_w);
    usum = op3[4] ? ({1'b0, z} - ({1'b0, mx[PW-1:0]} + cin_w))
                  : ({1'b0, z} + {1'b0, mx[PW-1:0]} + cin_w);
    ovf_now = sum[PW] ^ sum[PW-1];
    p_next  = sum[PW-1:0];
    if (SAT_EN && ovf_now) p_next = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    carry_next = SAT_EN ? 1'b0 : usum[PW];
    pdet_next  = ((p_next ^ PATTERN) & ~MASK) == '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p <= '0; out_valid <= 1'b0; carryout <= 1'b0; ovf <= 1'b0; pdet <= 1'b0;
    end else if (ce) begin
      out_valid <= v3;
      if (v3) begin
        p        <= p_next;
        carryout <= carry_next;
        pdet     <= pdet_next;
      end
      // A fresh overflow beats a simultaneous clear.
      if (v3 && ovf_now) ovf <= 1'b1;
      else if (ovf_clr)  ovf <= 1'b0;
    end
  end

  assign pcout = p;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: a wrapping instance with pattern 15000 and a
// saturating instance share the same stimulus.
module tb_dsp_mac_slice;

  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 1;

  logic clk, rstn, ce, in_valid, ovf_clr;
  logic [5:0] opmode;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c, pcin;

  logic signed [18:0] bcout_w, bcout_s;
  logic signed [36:0] m_w, m_s;
  logic signed [47:0] p_w, p_s, pcout_w, pcout_s;
  logic ov_w, ov_s, co_w, co_s, ovf_w, ovf_s, pdet_w, pdet_s;

  int checks = 0;
  int failures = 0;
  int ov_seen;

  dsp_mac_slice #(.SAT_EN(1'b0), .PATTERN(48'd15000), .MASK(48'd0)) dut_w (
    .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .opmode(opmode),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .ovf_clr(ovf_clr),
    .bcout(bcout_w), .m(m_w), .p(p_w), .pcout(pcout_w), .out_valid(ov_w),
    .carryout(co_w), .ovf(ovf_w), .pdet(pdet_w));

  dsp_mac_slice #(.SAT_EN(1'b1)) dut_s (
    .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .opmode(opmode),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .ovf_clr(ovf_clr),
    .bcout(bcout_s), .m(m_s), .p(p_s), .pcout(pcout_s), .out_valid(ov_s),
    .carryout(co_s), .ovf(ovf_s), .pdet(pdet_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int av, input int bv, input int dv, input longint cv,
                       input logic [5:0] op);
    a = 18'(av); b = 18'(bv); d = 18'(dv); c = 48'(cv); opmode = op;
  endtask

  initial begin
    rstn = 1'b0; ce = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
    pcin = '0;
    drive(0, 0, 0, 0, 6'b000000);
    tick(); tick();
    check("rst_p", longint'(p_w), 0);
    check("rst_m", longint'(m_w), 0);
    check("rst_bcout", longint'(bcout_w), 0);
    check("rst_valid", longint'(ov_w), 0);
    check("rst_ovf", longint'(ovf_w), 0);
    check("rst_pdet_pattern0", longint'(pdet_s), 0);
    rstn = 1'b1;

    // pre-add D+B, multiply, add C
    drive(10, 100, 1000, 4000, 6'b000101); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); check("pre_bcout", longint'(bcout_w), 1100); check("pre_valid_e2", longint'(ov_w), 0);
    tick(); check("pre_m", longint'(m_w), 11000); check("pre_valid_e3", longint'(ov_w), 0);
    tick(); check("pre_p", longint'(p_w), 15000); check("pre_valid_e4", longint'(ov_w), 1);
    check("pre_pcout", longint'(pcout_w), 15000); check("pre_pdet", longint'(pdet_w), 1);
    tick(); check("pre_valid_once", longint'(ov_w), 0); check("pre_p_hold", longint'(p_w), 15000);

    // pre-subtract D-B, post-subtract C - M
    drive(500, 120, 1050, 16000, 6'b010111); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); check("sub_bcout", longint'(bcout_w), 930);
    tick(); check("sub_m", longint'(m_w), 465000);
    tick(); check("sub_p", longint'(p_w), -449000); check("sub_valid", longint'(ov_w), 1);
    check("sub_ovf", longint'(ovf_w), 0); check("sub_pdet", longint'(pdet_w), 0);

    // back-to-back accumulate
    drive(2, 3, 0, 0, 6'b000000); in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) opmode = 6'b001000;
      if (i == 3) in_valid = 1'b0;
      if (i >= 3) begin
        check("acc_p", longint'(p_w), longint'(6 * (i - 2)));
        check("acc_valid", longint'(ov_w), 1);
      end
    end

    // positive overflow: clamp vs wrap, sticky flag
    drive(1, 1, 0, PMAX, 6'b000100); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    check("sat_p", longint'(p_s), PMAX); check("sat_ovf", longint'(ovf_s), 1);
    check("wrap_p", longint'(p_w), PMIN); check("wrap_ovf", longint'(ovf_w), 1);
    check("wrap_carry", longint'(co_w), 0);
    tick(); tick(); tick();
    check("sat_ovf_sticky", longint'(ovf_s), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("sat_ovf_clr", longint'(ovf_s), 0); check("wrap_ovf_clr", longint'(ovf_w), 0);

    // unsigned carry out with carry-in
    drive(1, 1, 0, -1, 6'b100100); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    check("cin_p", longint'(p_w), 1); check("cin_carry_wrap", longint'(co_w), 1);
    check("cin_carry_sat", longint'(co_s), 0); check("cin_ovf", longint'(ovf_w), 0);

    // three-cycle stall while the operation sits in the pre-adder stage
    drive(10, 100, 1000, 4000, 6'b000101); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); check("stall_bcout", longint'(bcout_w), 1100);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_p_frozen", longint'(p_w), 1);
      check("stall_valid", longint'(ov_w), 0);
      check("stall_bcout_frozen", longint'(bcout_w), 1100);
    end
    ce = 1'b1;
    tick(); check("stall_e6_p", longint'(p_w), 1); check("stall_e6_m", longint'(m_w), 11000);
    tick(); check("stall_p", longint'(p_w), 15000); check("stall_pdet", longint'(pdet_w), 1);
    check("stall_valid_e7", longint'(ov_w), 1);
    tick(); check("stall_valid_once", longint'(ov_w), 0);

    // reset with two operations in flight
    in_valid = 1'b1;
    tick(); tick(); in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_p", longint'(p_w), 0); check("mid_rst_bcout", longint'(bcout_w), 0);
    check("mid_rst_m", longint'(m_w), 0); check("mid_rst_pdet", longint'(pdet_w), 0);
    check("mid_rst_valid", longint'(ov_w), 0);
    tick(); rstn = 1'b1;
    drive(10, 100, 1000, 4000, 6'b000101); in_valid = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b0;
      if (i < 3) ov_seen += int'(ov_w);
    end
    check("post_rst_no_valid", longint'(ov_seen), 0);
    check("post_rst_p", longint'(p_w), 15000);
    check("post_rst_valid", longint'(ov_w), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
